// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs LANES of them into one word, flushing a partial word after TIMEOUT idle cycles.
// Latency: word valid on the edge capturing the last entry; while out_valid is held, pops stop (no internal buffering).
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  input  logic                   fifo_empty,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            word_count
);

  localparam int CW = $clog2(LANES + 1);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;
  localparam logic [CW:0]   LANES_W   = (CW + 1)'(LANES);

  logic [CW-1:0] cnt;
  logic          inflight;
  logic [IW-1:0] idle_cnt;
  logic [CW:0]   occupancy;
  logic          idle;
  logic          flush;
  logic          accept;

  // Occupancy counts the outstanding pop so the word never overfills.
  assign occupancy = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign idle      = (cnt != '0) && !inflight && fifo_empty && !out_valid && (TIMEOUT != 0);
  assign flush     = idle && (idle_cnt == IDLE_LAST);
  assign accept    = out_valid && out_ready;

  always_comb begin
    fifo_rd_en = !rd_rst && !fifo_empty && !out_valid && (occupancy < LANES_W);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cnt        <= '0;
      inflight   <= 1'b0;
      idle_cnt   <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      idle_cnt <= (idle && !flush) ? idle_cnt + IW'(1) : '0;
      if (accept) begin
        cnt        <= '0;
        out_data   <= '0;
        out_keep   <= '0;
        out_valid  <= 1'b0;
        word_count <= word_count + 16'd1;
      end else begin
        if (inflight) begin
          for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) begin
              out_data[i*WIDTH +: WIDTH] <= fifo_rd_data;
              out_keep[i]                <= 1'b1;
            end
          end
          cnt <= cnt + CW'(1);
          // With a capture pending, occupancy equals the post-capture lane count.
          if (occupancy == LANES_W) out_valid <= 1'b1;
        end
        if (flush) out_valid <= 1'b1;
      end
    end
  end

endmodule
